// File: rtl/mem_read_scheduler.sv
// Round-robin scheduler sharing one memory read port among NUM_REQ requesters.
// Ports: clk/reset; stall; req_valid/req_ready/req_bank/req_addr per requester;
// mem_reb/mem_bankb/mem_addrb/mem_dob to the memory; rsp_valid/rsp_data; busy.
module mem_read_scheduler #(
    parameter type type_t       = logic,
    parameter int  NUM_REQ      = 4,
    parameter int  NUM_BANKS    = 2,
    parameter int  DEPTH        = 32,
    parameter int  READ_LATENCY = 2,
    parameter int  BANK_WIDTH   = $clog2(NUM_BANKS),
    parameter int  ID_WIDTH     = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     stall,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic [NUM_REQ-1:0][BANK_WIDTH-1:0]       req_bank,
    input  logic [NUM_REQ-1:0][$clog2(DEPTH)-1:0]    req_addr,
    output logic                                     mem_reb,
    output logic [BANK_WIDTH-1:0]                    mem_bankb,
    output logic [$clog2(DEPTH)-1:0]                 mem_addrb,
    input  type_t                                    mem_dob,
    output logic [NUM_REQ-1:0]                       rsp_valid,
    output type_t                                    rsp_data,
    output logic                                     busy
);

    logic [ID_WIDTH-1:0]      ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]      gnt_id, cand;
    logic                     any_gnt;
    logic [BANK_WIDTH-1:0]    bank_q, bank_d;
    logic [$clog2(DEPTH)-1:0] addr_q, addr_d;

    // Scan from ptr upward (mod NUM_REQ); first valid requester wins.
    always_comb begin
        any_gnt = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        if (!stall && !reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = ID_WIDTH'((int'(ptr_q) + i) % NUM_REQ);
                if (!any_gnt && req_valid[cand]) begin
                    any_gnt = 1'b1;
                    gnt_id  = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready         = '0;
        req_ready[gnt_id] = any_gnt;
    end

    // Bank/address hold their last issued value on idle cycles.
    always_comb begin
        ptr_d  = ptr_q;
        bank_d = bank_q;
        addr_d = addr_q;
        if (any_gnt) begin
            ptr_d  = ID_WIDTH'((int'(gnt_id) + 1) % NUM_REQ);
            bank_d = req_bank[gnt_id];
            addr_d = req_addr[gnt_id];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            bank_q <= '0;
            addr_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            bank_q <= bank_d;
            addr_q <= addr_d;
        end
    end

    assign mem_reb   = any_gnt;
    assign mem_bankb = bank_d;
    assign mem_addrb = addr_d;
    assign rsp_data  = mem_dob;

    if (READ_LATENCY == 0) begin : g_comb
        assign rsp_valid = req_valid & req_ready;
        assign busy      = 1'b0;
    end else begin : g_pipe
        logic [READ_LATENCY-1:0]               pv_q, pv_d;
        logic [READ_LATENCY-1:0][ID_WIDTH-1:0] pid_q, pid_d;

        // Tracking shift register mirrors the memory's fixed read delay.
        always_comb begin
            pv_d     = '0;
            pid_d    = '0;
            pv_d[0]  = any_gnt;
            pid_d[0] = gnt_id;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_d[i]  = pv_q[i-1];
                pid_d[i] = pid_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pv_q  <= '0;
                pid_q <= '0;
            end else begin
                pv_q  <= pv_d;
                pid_q <= pid_d;
            end
        end

        always_comb begin
            rsp_valid = '0;
            rsp_valid[pid_q[READ_LATENCY-1]] = pv_q[READ_LATENCY-1];
        end

        assign busy = |pv_q;
    end

endmodule

// File: tb/tb_mem_read_scheduler.sv
// Scoreboard bench for mem_read_scheduler: a READ_LATENCY=2 / 2-bank instance
// and a READ_LATENCY=0 / 4-bank instance, each behind a simple memory model.
module tb_mem_read_scheduler;

    typedef struct {
        logic [3:0] oh;
        logic [7:0] d;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // latency-2 instance
    logic [3:0]      rv2 = '0, rdy2, rsv2;
    logic [3:0][0:0] bank2;
    logic [3:0][4:0] addr2;
    logic            reb2, busy2;
    logic [0:0]      bankb2;
    logic [4:0]      addrb2;
    logic [7:0]      dob2, rsd2, m1, m2;

    // latency-0 instance
    logic [3:0]      rv0 = '0, rdy0, rsv0;
    logic [3:0][1:0] bank0;
    logic [3:0][4:0] addr0;
    logic            reb0, busy0;
    logic [1:0]      bankb0;
    logic [4:0]      addrb0;
    logic [7:0]      dob0, rsd0;

    exp_t q2[$];
    exp_t q0[$];
    exp_t m2e, m0e;
    logic [1:0] hist = '0;
    logic [0:0] last_b2 = '0;
    logic [4:0] last_a2 = '0;
    logic [1:0] last_b0 = '0;
    logic [4:0] last_a0 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_word(int b, int a);
        return 8'(8'h90 + 16 * b + a);
    endfunction

    mem_read_scheduler #(
        .type_t(logic [7:0]), .NUM_REQ(4), .NUM_BANKS(2),
        .DEPTH(32), .READ_LATENCY(2)
    ) u_dut2 (
        .clk(clk), .reset(reset), .stall(stall),
        .req_valid(rv2), .req_ready(rdy2),
        .req_bank(bank2), .req_addr(addr2),
        .mem_reb(reb2), .mem_bankb(bankb2), .mem_addrb(addrb2),
        .mem_dob(dob2), .rsp_valid(rsv2), .rsp_data(rsd2), .busy(busy2)
    );

    mem_read_scheduler #(
        .type_t(logic [7:0]), .NUM_REQ(4), .NUM_BANKS(4),
        .DEPTH(32), .READ_LATENCY(0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .stall(stall),
        .req_valid(rv0), .req_ready(rdy0),
        .req_bank(bank0), .req_addr(addr0),
        .mem_reb(reb0), .mem_bankb(bankb0), .mem_addrb(addrb0),
        .mem_dob(dob0), .rsp_valid(rsv0), .rsp_data(rsd0), .busy(busy0)
    );

    // Memory models: two-cycle registered read, and combinational read.
    always @(posedge clk) begin
        m1 <= reb2 ? mem_word(int'(bankb2), int'(addrb2)) : 8'h00;
        m2 <= m1;
    end
    assign dob2 = m2;
    assign dob0 = mem_word(int'(bankb0), int'(addrb0));

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Response monitors pop the scoreboards whenever a response is shown.
    always @(negedge clk) begin
        while (q2.size() > 0 && q2[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL rsp2_missing: got none want %h due %0d",
                     q2[0].oh, q2[0].due);
            void'(q2.pop_front());
        end
        if (rsv2 != 4'b0) begin
            if (q2.size() == 0) begin
                chk("rsp2_spurious", rsv2, 0);
            end else begin
                m2e = q2.pop_front();
                chk("rsp2_valid", rsv2, m2e.oh);
                chk("rsp2_data", rsd2, m2e.d);
                chk("rsp2_cycle", cyc, m2e.due);
            end
        end
    end

    always @(negedge clk) begin
        while (q0.size() > 0 && q0[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL rsp0_missing: got none want %h due %0d",
                     q0[0].oh, q0[0].due);
            void'(q0.pop_front());
        end
        if (rsv0 != 4'b0) begin
            if (q0.size() == 0) begin
                chk("rsp0_spurious", rsv0, 0);
            end else begin
                m0e = q0.pop_front();
                chk("rsp0_valid", rsv0, m0e.oh);
                chk("rsp0_data", rsd0, m0e.d);
                chk("rsp0_cycle", cyc, m0e.due);
            end
        end
    end

    // One cycle of stimulus: z selects the latency-0 instance; ex is the
    // hand-computed expected one-hot grant.
    task automatic vec(input bit z, input logic [3:0] v, input bit st,
                       input logic [3:0] ex);
        int   g;
        exp_t e;
        logic [3:0] ex2, ex0;
        g = -1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        stall = st;
        rv2 = z ? 4'b0 : v;
        rv0 = z ? v : 4'b0;
        ex2 = z ? 4'b0 : ex;
        ex0 = z ? ex : 4'b0;
        for (int i = 0; i < 4; i++) if (ex[i]) g = i;
        #2;
        chk("ready2", rdy2, ex2);
        chk("reb2", reb2, |ex2);
        chk("busy2", busy2, |hist);
        if (!z && g >= 0) begin
            last_b2 = bank2[g];
            last_a2 = addr2[g];
            e.oh = ex2;
            e.d = mem_word(int'(bank2[g]), int'(addr2[g]));
            e.due = cyc + 2;
            q2.push_back(e);
        end
        chk("bankb2", bankb2, last_b2);
        chk("addrb2", addrb2, last_a2);
        hist = {hist[0], (!z && g >= 0)};
        chk("ready0", rdy0, ex0);
        chk("reb0", reb0, |ex0);
        chk("busy0", busy0, 0);
        if (z && g >= 0) begin
            last_b0 = bank0[g];
            last_a0 = addr0[g];
            e.oh = ex0;
            e.d = mem_word(int'(bank0[g]), int'(addr0[g]));
            e.due = cyc;
            q0.push_back(e);
        end
        chk("bankb0", bankb0, last_b0);
        chk("addrb0", addrb0, last_a0);
    endtask

    // Reset with all requests asserted: every output must read zero.
    task automatic rst(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            stall = 1'b0;
            rv2 = 4'b1111;
            rv0 = 4'b1111;
            #2;
            q2.delete();
            q0.delete();
            hist = '0;
            last_b2 = '0;
            last_a2 = '0;
            last_b0 = '0;
            last_a0 = '0;
            chk("rst_ready2", rdy2, 0);
            chk("rst_reb2", reb2, 0);
            chk("rst_bankb2", bankb2, 0);
            chk("rst_addrb2", addrb2, 0);
            chk("rst_rsp2", rsv2, 0);
            chk("rst_busy2", busy2, 0);
            chk("rst_ready0", rdy0, 0);
            chk("rst_rsp0", rsv0, 0);
        end
    endtask

    initial begin
        bank2[0] = 1'b0; addr2[0] = 5'd3;
        bank2[1] = 1'b1; addr2[1] = 5'd5;
        bank2[2] = 1'b0; addr2[2] = 5'd9;
        bank2[3] = 1'b1; addr2[3] = 5'd12;
        bank0[0] = 2'd0; addr0[0] = 5'd7;
        bank0[1] = 2'd3; addr0[1] = 5'd7;
        bank0[2] = 2'd2; addr0[2] = 5'd7;
        bank0[3] = 2'd1; addr0[3] = 5'd7;

        rst(2);
        // single requester 1: bank 1 addr 5 -> 0xA5
        vec(0, 4'b0010, 0, 4'b0010);
        repeat (3) vec(0, 4'b0000, 0, 4'b0000);

        // round robin from reset
        rst(1);
        vec(0, 4'b1111, 0, 4'b0001);
        vec(0, 4'b1111, 0, 4'b0010);
        vec(0, 4'b1111, 0, 4'b0100);
        vec(0, 4'b1111, 0, 4'b1000);
        vec(0, 4'b1111, 0, 4'b0001);

        // pointer wrap: grant 2 leaves ptr=3
        vec(0, 4'b0100, 0, 4'b0100);
        vec(0, 4'b1001, 0, 4'b1000);
        vec(0, 4'b1001, 0, 4'b0001);
        repeat (2) vec(0, 4'b0000, 0, 4'b0000);

        // stall with one read in flight
        vec(0, 4'b0010, 0, 4'b0010);
        repeat (3) vec(0, 4'b1101, 1, 4'b0000);
        vec(0, 4'b1101, 0, 4'b0100);
        vec(0, 4'b1101, 0, 4'b1000);
        vec(0, 4'b1101, 0, 4'b0001);
        repeat (2) vec(0, 4'b0000, 0, 4'b0000);

        // reset one cycle after a grant
        vec(0, 4'b0001, 0, 4'b0001);
        rst(1);
        repeat (4) vec(0, 4'b0000, 0, 4'b0000);

        // zero latency, banks 0/3/2 at address 7
        vec(1, 4'b0001, 0, 4'b0001);
        vec(1, 4'b0010, 0, 4'b0010);
        vec(1, 4'b0100, 0, 4'b0100);
        vec(1, 4'b0001, 0, 4'b0001);
        vec(1, 4'b1111, 0, 4'b0010);
        vec(1, 4'b1111, 0, 4'b0100);
        repeat (3) vec(0, 4'b0000, 0, 4'b0000);

        @(negedge clk);
        chk("q2_drained", q2.size(), 0);
        chk("q0_drained", q0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_read_scheduler.md
# mem_read_scheduler

Round-robin read-port scheduler for a multi-bank simple-dual-port memory. It shares the single read port (`reb`/`bankb`/`addrb`/`dob`) among `NUM_REQ` requesters, such as the operator pipeline, the debug readback path and the envelope/phase state readers. It issues at most one read per cycle and tracks each read through the memory's fixed output latency. It then routes the returned word back to the requester that issued it. The write port is not touched by this block.

## Interface
- `type_t`, `logic`: memory word type; must match the memory instance.
- `NUM_REQ`, `4`: number of requesters, at least 1.
- `NUM_BANKS`, `2`: banks in the memory, at least 2.
- `DEPTH`, `32`: words per bank.
- `READ_LATENCY`, `2`: memory read delay in cycles, one of 0, 1 or 2. Must equal the memory's `OUTPUT_DELAY`.
- `BANK_WIDTH`, `$clog2(NUM_BANKS)`.
- `ID_WIDTH`, `NUM_REQ > 1 ? $clog2(NUM_REQ) : 1`.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `stall`  in  1  when high, no new grants; in-flight reads still complete.
- `req_valid`  in  `[NUM_REQ]`  read request.
- `req_ready`  out  `[NUM_REQ]`  one-hot grant; the read is accepted when valid and ready are both high.
- `req_bank`  in  `[NUM_REQ][BANK_WIDTH]`  bank per requester.
- `req_addr`  in  `[NUM_REQ][$clog2(DEPTH)]`  address per requester.
- `mem_reb`  out  1  read enable to memory.
- `mem_bankb`  out  `BANK_WIDTH`  read bank to memory.
- `mem_addrb`  out  `$clog2(DEPTH)`  read address to memory.
- `mem_dob`  in  `type_t`  memory read data.
- `rsp_valid`  out  `[NUM_REQ]`  one-hot; the word for that requester is on `rsp_data` this cycle.
- `rsp_data`  out  `type_t`  equal to `mem_dob`, shared by all requesters.
- `busy`  out  1  at least one read is in flight.

## Operation
- **Pointer.** Round-robin pointer `ptr` (`ID_WIDTH` bits) resets to 0.
- **Grant selection (combinational).** Scan requesters `ptr`, `ptr+1`, … mod `NUM_REQ`. The first one with `req_valid` high gets `req_ready`. Suppress all grants when `stall` or `reset` is high.
- **Grant cycle.**
  - `mem_reb` = 1.
  - `mem_bankb` / `mem_addrb` = the granted requester's `req_bank` / `req_addr`.
- **Idle cycle.**
  - `mem_reb` = 0.
  - `mem_bankb` / `mem_addrb` hold their last issued values (registered hold, reset 0), so no spurious read glitches reach the bank mux.
- **Pointer update.** On a grant to requester `g`, `ptr` ← (`g`+1) mod `NUM_REQ`. With no grant, `ptr` is unchanged.
- **Starvation bound.** A continuously asserted request is granted within `NUM_REQ` non-stalled cycles.
- **Requester rules.**
  - A requester may deassert `req_valid` before it is granted; it is simply skipped.
  - Its bank and address are sampled only in the grant cycle.
- **Tracking pipeline.** Entries of {valid, id}, `READ_LATENCY` deep, shifted every cycle with no backpressure.
  - Stage 0 loads {grant, granted id}.
  - `rsp_valid[id]` is driven from the last stage.
- **`READ_LATENCY` = 0.** No pipeline; `rsp_valid` = `req_valid & req_ready`, combinational in the same cycle.
- **Responses.** Requesters must accept a response in the cycle it is presented; there is no response flow control.
- **`busy`.** OR of the pipeline valid bits; constant 0 when `READ_LATENCY` = 0.
- **Bank range.** A `req_bank` value of `NUM_BANKS` or above is passed through unchecked. The memory's behaviour for it is undefined; the bench must not drive it.

## Timing
- **Reset values:** `req_ready` = 0, `mem_reb` = 0, `mem_bankb` = 0, `mem_addrb` = 0, `rsp_valid` = 0, `busy` = 0, `ptr` = 0, pipeline cleared.
- **Reset mid-operation:** in-flight reads are discarded, and no `rsp_valid` is produced for them after reset releases.
- **Throughput:** one read per cycle, back-to-back, across any mix of requesters and banks.
- **Latency:** a grant at edge *t* gives `rsp_valid` in the cycle starting at edge *t*+`READ_LATENCY`. Response order equals grant order.
- **Stall:** `stall` acts combinationally on the grant in the same cycle. It has no effect on the tracking pipeline or `ptr`.
- **`NUM_REQ` = 1:** `ptr` is a constant 0, and the grant is `req_valid & ~stall`.

## Test plan
- **Single requester.** `READ_LATENCY` = 2. Requester 1 reads bank 1, address 5, holding 0xA5. Expect `req_ready[1]` in the same cycle, `mem_reb` = 1 with `bankb` = 1 and `addrb` = 5, then `rsp_valid` = 4'b0010 with `rsp_data` = 0xA5 exactly 2 cycles later. `busy` is high for 2 cycles.
- **Round robin.** All 4 requesters hold `req_valid` from reset. Expect grants in order 0, 1, 2, 3, 0 on consecutive cycles, and the `rsp_valid` one-hot sequence repeats that order 2 cycles later with each requester's own data.
- **Pointer wrap.** With `ptr` = 3 after granting requester 2, only requesters 0 and 3 request. Expect 3 to be granted, then 0.
- **Stall.** Stall for 3 cycles while requests are pending, with one read in flight. Expect no grants and the in-flight response to arrive on time. The first grant after stall goes to the requester at `ptr`.
- **Reset mid-flight.** Assert `reset` one cycle after a grant, with `READ_LATENCY` = 2. Expect all outputs at 0 immediately and no `rsp_valid` for 4 cycles after release.
- **Zero latency.** `READ_LATENCY` = 0, `NUM_BANKS` = 4. Alternate reads of banks 0, 3, 2 at address 7. Expect `rsp_valid` and the correct per-bank data in the grant cycle itself.
